wb_port_arbiter: RTL and testbench

//  Drives the single register-file write port (we/waddr/wdata) from two result sources:
//  the in-order pipeline writeback (highest priority, never stalled) and a long-latency unit (LU,
//  e.g. divider/load) via valid/ready handshake. LU results are buffered in a small FIFO and

---
 rtl/wb_port_arbiter_if.sv | 33 +++
 rtl/wb_port_arbiter.sv | 102 ++++++++++
 tb/tb_wb_port_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_if.sv
// Register-file write-port bundle: pipeline writeback, LU result handshake, write port, busy map.
// No storage; latency and backpressure belong to the arbiter that uses it.
// LU side is valid/ready; the pipeline side has no backpressure.
interface wb_port_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic                   pipe_we;
    logic [ADDR_W-1:0]      pipe_waddr;
    logic [DATA_W-1:0]      pipe_wdata;
    logic                   lu_valid;
    logic                   lu_ready;
    logic [ADDR_W-1:0]      lu_waddr;
    logic [DATA_W-1:0]      lu_wdata;
    logic                   we;
    logic [ADDR_W-1:0]      waddr;
    logic [DATA_W-1:0]      wdata;
    logic [2**ADDR_W-1:0]   busy;

    modport master (
        output pipe_we, pipe_waddr, pipe_wdata,
        output lu_valid, lu_waddr, lu_wdata,
        input  lu_ready,
        input  we, waddr, wdata, busy
    );

    modport slave (
        input  pipe_we, pipe_waddr, pipe_wdata,
        input  lu_valid, lu_waddr, lu_wdata,
        output lu_ready,
        output we, waddr, wdata, busy
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares one regfile write port between pipeline writeback and a FIFO of long-latency results.
// Latency: pipeline write 1 cycle; LU result at least 2 cycles after its handshake.
// Backpressure: lu_ready drops only when the FIFO is full; the pipeline is never stalled.
module wb_port_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 2
) (
    input logic                 clk,
    input logic                 rst,
    wb_port_arbiter_if.slave    bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREG  = 2**ADDR_W;

    logic [FIFO_DEPTH-1:0]  ent_vld;
    logic [ADDR_W-1:0]      ent_addr [FIFO_DEPTH];
    logic [DATA_W-1:0]      ent_data [FIFO_DEPTH];
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;
    logic [CNT_W-1:0]       count;

    logic                   we_q;
    logic [ADDR_W-1:0]      waddr_q;
    logic [DATA_W-1:0]      wdata_q;
    logic [NREG-1:0]        busy_map;

    logic pipe_live;
    logic lu_fire;
    logic push;
    logic push_vld;
    logic pop;

    assign pipe_live    = bus.pipe_we && (bus.pipe_waddr != '0);
    assign bus.lu_ready = rst && (count < CNT_W'(FIFO_DEPTH));
    assign lu_fire      = bus.lu_valid && bus.lu_ready;
    assign push         = lu_fire && (bus.lu_waddr != '0);
    // A same-cycle pipe write to the same register is younger, so the new entry lands already dead.
    assign push_vld     = !(pipe_live && (bus.lu_waddr == bus.pipe_waddr));
    assign pop          = !pipe_live && (count != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent_vld <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                ent_addr[i] <= '0;
                ent_data[i] <= '0;
            end
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (pipe_live && (ent_addr[i] == bus.pipe_waddr)) begin
                    ent_vld[i] <= 1'b0;
                end
            end
            if (pop) begin
                ent_vld[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + PTR_W'(1);
            end
            // push never targets the head slot while popping: lu_ready is low when full
            if (push) begin
                ent_vld[wr_ptr]  <= push_vld;
                ent_addr[wr_ptr] <= bus.lu_waddr;
                ent_data[wr_ptr] <= bus.lu_wdata;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);

            if (pipe_live) begin
                we_q    <= 1'b1;
                waddr_q <= bus.pipe_waddr;
                wdata_q <= bus.pipe_wdata;
            end else if (pop && ent_vld[rd_ptr]) begin
                we_q    <= 1'b1;
                waddr_q <= ent_addr[rd_ptr];
                wdata_q <= ent_data[rd_ptr];
            end else begin
                we_q    <= 1'b0;
            end
        end
    end

    always_comb begin
        busy_map = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (ent_vld[i]) begin
                busy_map[ent_addr[i]] = 1'b1;
            end
        end
    end

    assign bus.we    = we_q;
    assign bus.waddr = waddr_q;
    assign bus.wdata = wdata_q;
    assign bus.busy  = busy_map;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed vector bench for wb_port_arbiter: table of per-cycle stimulus/expectations plus a reset sequence.
module tb_wb_port_arbiter;
    logic clk;
    logic rst;

    wb_port_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        pwe;
        logic [4:0]  pa;
        logic [31:0] pd;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic        rdy;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] busy;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                                input logic lv, input logic [4:0] la, input logic [31:0] ld,
                                input logic rdy, input logic we, input logic [4:0] wa,
                                input logic [31:0] wd, input logic [31:0] busy);
        vec_t v;
        v.pwe = pwe; v.pa = pa; v.pd = pd;
        v.lv = lv; v.la = la; v.ld = ld;
        v.rdy = rdy; v.we = we; v.wa = wa; v.wd = wd; v.busy = busy;
        return v;
    endfunction

    initial begin
        //            pwe pa  pd            lv la  ld       rdy we wa  wd            busy
        vecs[0]  = mk(1, 5,  32'hAAAA5555, 0, 0,  0,       1,  1, 5,  32'hAAAA5555, 32'h0);
        vecs[1]  = mk(0, 0,  0,            1, 7,  32'h12,  1,  0, 5,  32'hAAAA5555, 32'h1 << 7);
        vecs[2]  = mk(0, 0,  0,            0, 0,  0,       1,  1, 7,  32'h12,       32'h0);
        vecs[3]  = mk(1, 3,  32'h33,       1, 10, 32'hA0,  1,  1, 3,  32'h33,       32'h1 << 10);
        vecs[4]  = mk(1, 3,  32'h34,       1, 11, 32'hB0,  1,  1, 3,  32'h34,       32'h3 << 10);
        vecs[5]  = mk(1, 3,  32'h35,       1, 12, 32'hC0,  0,  1, 3,  32'h35,       32'h3 << 10);
        vecs[6]  = mk(0, 0,  0,            1, 12, 32'hC0,  0,  1, 10, 32'hA0,       32'h1 << 11);
        vecs[7]  = mk(0, 0,  0,            1, 12, 32'hC0,  1,  1, 11, 32'hB0,       32'h1 << 12);
        vecs[8]  = mk(0, 0,  0,            0, 0,  0,       1,  1, 12, 32'hC0,       32'h0);
        vecs[9]  = mk(0, 0,  0,            1, 9,  32'h99,  1,  0, 12, 32'hC0,       32'h1 << 9);
        vecs[10] = mk(1, 9,  32'h909,      0, 0,  0,       1,  1, 9,  32'h909,      32'h0);
        vecs[11] = mk(0, 0,  0,            0, 0,  0,       1,  0, 9,  32'h909,      32'h0);
        vecs[12] = mk(1, 4,  32'h44,       1, 4,  32'h4F,  1,  1, 4,  32'h44,       32'h0);
        vecs[13] = mk(0, 0,  0,            0, 0,  0,       1,  0, 4,  32'h44,       32'h0);
        vecs[14] = mk(0, 0,  0,            1, 6,  32'h66,  1,  0, 4,  32'h44,       32'h1 << 6);
        vecs[15] = mk(1, 0,  32'hDEAD,     1, 0,  32'h77,  1,  1, 6,  32'h66,       32'h0);
        vecs[16] = mk(0, 0,  0,            1, 0,  32'h78,  1,  0, 6,  32'h66,       32'h0);

        rst = 1'b0;
        bus.pipe_we = 1'b0; bus.pipe_waddr = '0; bus.pipe_wdata = '0;
        bus.lu_valid = 1'b0; bus.lu_waddr = '0; bus.lu_wdata = '0;

        #3;
        check("reset we", 64'(bus.we), 64'd0);
        check("reset waddr", 64'(bus.waddr), 64'd0);
        check("reset wdata", 64'(bus.wdata), 64'd0);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset lu_ready", 64'(bus.lu_ready), 64'd0);
        step();
        rst = 1'b1;
        #1;
        check("post-reset lu_ready", 64'(bus.lu_ready), 64'd1);

        for (int i = 0; i < 17; i++) begin
            bus.pipe_we    = vecs[i].pwe;
            bus.pipe_waddr = vecs[i].pa;
            bus.pipe_wdata = vecs[i].pd;
            bus.lu_valid   = vecs[i].lv;
            bus.lu_waddr   = vecs[i].la;
            bus.lu_wdata   = vecs[i].ld;
            #1;
            check($sformatf("row%0d lu_ready", i), 64'(bus.lu_ready), 64'(vecs[i].rdy));
            step();
            check($sformatf("row%0d we", i), 64'(bus.we), 64'(vecs[i].we));
            check($sformatf("row%0d waddr", i), 64'(bus.waddr), 64'(vecs[i].wa));
            check($sformatf("row%0d wdata", i), 64'(bus.wdata), 64'(vecs[i].wd));
            check($sformatf("row%0d busy", i), 64'(bus.busy), 64'(vecs[i].busy));
        end

        // Reset with two queued entries: pipe keeps the port so nothing drains.
        bus.pipe_we = 1'b1; bus.pipe_waddr = 5'd1; bus.pipe_wdata = 32'h11;
        bus.lu_valid = 1'b1; bus.lu_waddr = 5'd13; bus.lu_wdata = 32'hD0;
        step();
        bus.lu_waddr = 5'd14; bus.lu_wdata = 32'hE0;
        step();
        bus.lu_valid = 1'b0;
        #1;
        check("full busy", 64'(bus.busy), 64'((32'h1 << 13) | (32'h1 << 14)));
        check("full lu_ready", 64'(bus.lu_ready), 64'd0);
        check("full we", 64'(bus.we), 64'd1);
        #1;
        rst = 1'b0;
        #1;
        check("async rst we", 64'(bus.we), 64'd0);
        check("async rst busy", 64'(bus.busy), 64'd0);
        check("async rst lu_ready", 64'(bus.lu_ready), 64'd0);
        check("async rst waddr", 64'(bus.waddr), 64'd0);
        bus.pipe_we = 1'b0;
        bus.lu_valid = 1'b1; bus.lu_waddr = 5'd15; bus.lu_wdata = 32'hF0;
        step();
        check("in rst lu_ready", 64'(bus.lu_ready), 64'd0);
        step();
        rst = 1'b1;
        bus.lu_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            check($sformatf("post-rst%0d we", c), 64'(bus.we), 64'd0);
            check($sformatf("post-rst%0d busy", c), 64'(bus.busy), 64'd0);
        end
        check("post-rst lu_ready", 64'(bus.lu_ready), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
